// File: rtl/stepper_driver.sv
// Move-based unipolar stepper sequencer: paces steps from a clock divider,
// tracks absolute position in half-step units and reports busy/done.
module stepper_driver #(
    parameter int CLK_DIV = 1000000,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] steps,
    input  logic             dir,
    input  logic             half,
    input  logic             stop,
    input  logic             hold,
    output logic [3:0]       coil,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pos
);
    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    typedef struct packed {
        logic [CNT_W-1:0] remaining;
        logic             dir;
        logic             half;
    } move_t;

    logic [0:0]       state;
    move_t            mv;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       idx;
    logic [2:0]       istep;
    logic [2:0]       idx_nxt;
    logic [CNT_W-1:0] pos_nxt;
    logic             tick;

    assign istep   = mv.half ? 3'd1 : 3'd2;
    assign idx_nxt = mv.dir ? idx + istep : idx - istep;
    assign pos_nxt = mv.dir ? pos + CNT_W'(istep) : pos - CNT_W'(istep);
    assign tick    = (div_cnt == DIV_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            mv      <= '0;
            div_cnt <= '0;
            idx     <= '0;
            pos     <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (steps == '0) begin
                            done <= 1'b1;
                        end else begin
                            state        <= S_RUN;
                            mv.remaining <= steps;
                            mv.dir       <= dir;
                            mv.half      <= half;
                            div_cnt      <= '0;
                        end
                    end
                end
                default: begin
                    // stop beats a coincident tick: no step is taken on that edge
                    if (stop) begin
                        state   <= S_IDLE;
                        done    <= 1'b1;
                        div_cnt <= '0;
                    end else if (tick) begin
                        div_cnt      <= '0;
                        idx          <= idx_nxt;
                        pos          <= pos_nxt;
                        mv.remaining <= mv.remaining - 1'b1;
                        if (mv.remaining == CNT_W'(1)) begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign busy = (state == S_RUN);

    always_comb begin
        coil = 4'h0;
        if (busy || hold) begin
            case (idx)
                3'd0:    coil = 4'h8;
                3'd1:    coil = 4'hC;
                3'd2:    coil = 4'h4;
                3'd3:    coil = 4'h6;
                3'd4:    coil = 4'h2;
                3'd5:    coil = 4'h3;
                3'd6:    coil = 4'h1;
                default: coil = 4'h9;
            endcase
        end
    end
endmodule

// File: tb/tb_stepper_driver.sv
// Directed bench for stepper_driver; steps are checked against a queue of
// expected {coil,pos} pushed when each move is launched.
module tb_stepper_driver;
    localparam int CLK_DIV = 4;
    localparam int CNT_W   = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] steps = '0;
    logic             dir   = 1'b0;
    logic             half  = 1'b0;
    logic             stop  = 1'b0;
    logic             hold  = 1'b1;
    logic [3:0]       coil;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pos;

    stepper_driver #(.CLK_DIV(CLK_DIV), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .start(start), .steps(steps),
        .dir(dir), .half(half), .stop(stop), .hold(hold),
        .coil(coil), .busy(busy), .done(done), .pos(pos)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]       coil;
        logic [CNT_W-1:0] pos;
    } exp_t;

    exp_t             q[$];
    logic [3:0]       pat [8] = '{4'h8, 4'hC, 4'h4, 4'h6, 4'h2, 4'h3, 4'h1, 4'h9};
    logic [2:0]       m_idx = '0;
    logic [CNT_W-1:0] m_pos = '0;
    logic [CNT_W-1:0] prev_pos = '0;
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int busy_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference motion model: queue the expected result of each step.
    task automatic push_move(input int n, input logic d, input logic h);
        logic [2:0] s;
        s = h ? 3'd1 : 3'd2;
        for (int i = 0; i < n; i++) begin
            m_idx = d ? m_idx + s : m_idx - s;
            m_pos = d ? m_pos + CNT_W'(s) : m_pos - CNT_W'(s);
            q.push_back('{coil: pat[m_idx], pos: m_pos});
        end
    endtask

    // Advance one cycle; sample at the falling edge and score any step taken.
    task automatic tick();
        exp_t e;
        @(negedge clock);
        if (done) done_cnt++;
        if (busy) busy_cnt++;
        if (!reset && pos !== prev_pos) begin
            if (q.size() == 0) begin
                chk("sb_unexpected_step", q.size(), 1);
            end else begin
                e = q.pop_front();
                chk("sb_coil", coil, e.coil);
                chk("sb_pos", pos, e.pos);
            end
        end
        prev_pos = pos;
    endtask

    task automatic launch(input int n, input logic d, input logic h);
        start = 1'b1; steps = CNT_W'(n); dir = d; half = h;
        tick();
        start = 1'b0; steps = '0;
    endtask

    initial begin
        bit got;
        // reset with hold
        tick(); tick();
        chk("rst_coil_hold", coil, 4'h8);
        chk("rst_pos", pos, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;
        tick();
        hold = 1'b0;
        tick();
        chk("rst_coil_release", coil, 4'h0);
        hold = 1'b1;

        // 4 full steps forward: 4,2,1,8, done only at the last step edge
        push_move(4, 1'b1, 1'b0);
        launch(4, 1'b1, 1'b0);
        chk("m1_busy_start", busy, 1);
        done_cnt = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 15) chk("m1_no_early_done", done_cnt, 0);
        end
        chk("m1_done_at_16", done, 1);
        chk("m1_busy_fall", busy, 0);
        chk("m1_pos", pos, 8);
        tick();
        chk("m1_done_one_cycle", done, 0);

        // reverse half steps from idx 0 / pos 0: 9,1,3 and pos wraps to 253
        reset = 1'b1; tick(); reset = 1'b0;
        m_idx = '0; m_pos = '0;
        push_move(3, 1'b0, 1'b1);
        busy_cnt = 0; done_cnt = 0;
        launch(3, 1'b0, 1'b1);
        for (int k = 0; k < 19; k++) tick();
        chk("m2_busy_cycles", busy_cnt, 12);
        chk("m2_done_cnt", done_cnt, 1);
        chk("m2_pos_wrap", pos, 253);

        // zero-length move
        busy_cnt = 0;
        launch(0, 1'b1, 1'b0);
        chk("z_done", done, 1);
        chk("z_busy", busy, 0);
        tick();
        chk("z_done_clear", done, 0);
        chk("z_coil", coil, pat[m_idx]);
        chk("z_pos", pos, m_pos);
        chk("z_busy_never", busy_cnt, 0);

        // 10-step move aborted on the third tick edge; a mid-move start is ignored
        push_move(2, 1'b1, 1'b1);
        done_cnt = 0;
        launch(10, 1'b1, 1'b1);
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 5) begin start = 1'b1; steps = 8'd5; dir = 1'b0; half = 1'b0; end
            if (k == 6) begin start = 1'b0; steps = '0; end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_done", done, 1);
        for (int k = 0; k < 8; k++) tick();
        chk("stop_done_once", done_cnt, 1);
        chk("stop_pos", pos, m_pos);
        chk("stop_coil", coil, pat[m_idx]);

        // back-to-back: second start in the done cycle
        push_move(2, 1'b1, 1'b0);
        launch(2, 1'b1, 1'b0);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            got = done;
        end
        chk("b2b_first_done", got, 1);
        push_move(1, 1'b0, 1'b1);
        launch(1, 1'b0, 1'b1);
        chk("b2b_accepted", busy, 1);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            got = done;
        end
        chk("b2b_second_done", got, 1);
        chk("b2b_pos", pos, m_pos);

        // reset mid-move after one step: no done, idx/pos cleared
        push_move(1, 1'b1, 1'b1);
        done_cnt = 0;
        launch(5, 1'b1, 1'b1);
        for (int k = 0; k < 6; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_idx = '0; m_pos = '0;
        chk("rmid_pos", pos, 0);
        chk("rmid_coil", coil, 4'h8);
        chk("rmid_busy", busy, 0);
        for (int k = 0; k < 8; k++) tick();
        chk("rmid_no_done", done_cnt, 0);
        chk("sb_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stepper_driver.md
# stepper_driver

Parametrised unipolar stepper-motor sequencer for the I/O interface. It replaces the free-running four-phase driver with a move-based controller. A move is launched with a start pulse and carries a step count, direction and full/half-step mode. The block paces steps from an internal clock divider, tracks absolute position, and reports busy/done to the traffic-control logic. The coil outputs feed the external driver transistors directly.

## Interface
- CLK_DIV, 1000000: clock cycles per step; legal range ≥ 2.
- CNT_W, 16: width of the step-count request and the position counter.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle move request; sampled only in IDLE.
- steps  in  CNT_W  number of steps for the move; latched on start.
- dir  in  1  1 = forward (index +), 0 = reverse; latched on start.
- half  in  1  1 = half-step mode, 0 = full-step mode; latched on start.
- stop  in  1  abort the current move; ignored in IDLE.
- hold  in  1  1 = keep the coil energised while idle, 0 = release the coil (coil = 0) while idle.
- coil  out  4  coil drive pattern {A,B,C,D}.
- busy  out  1  high during a move.
- done  out  1  one-cycle pulse at the end of a move (completed, zero-length or aborted).
- pos  out  CNT_W  absolute position in half-step units; wraps modulo 2^CNT_W.

## Operation
- 3-bit phase index `idx`, mapped to coil patterns:
  - idx 0..7 → 8, C, 4, 6, 2, 3, 1, 9 (hex).
- Index step size per motor step:
  - half = 1: ±1.
  - half = 0: ±2.
  - Index arithmetic is mod 8.
  - A full-step move from an even idx gives single-coil wave drive (8, 4, 2, 1).
  - A full-step move from an odd idx gives two-coil drive (C, 6, 3, 9). This is intended; no realignment is performed.
- pos changes by the same signed amount as idx per step (±1 or ±2), at CNT_W width with wrap.
- FSM states:
  - IDLE: busy = 0.
    - start with steps ≠ 0 → RUN. Latch steps into `remaining`; latch dir and half; clear the divider.
    - start with steps = 0 → stay in IDLE, pulse done next edge. No motion, no pos change.
  - RUN: busy = 1. The divider counts 0..CLK_DIV−1.
    - At terminal count (a "tick"): advance idx and pos, decrement `remaining`, reset the divider.
    - The tick that takes `remaining` to 0 → IDLE and pulse done on the same edge.
    - stop = 1 → IDLE at the next edge with no further step and done pulsed. If stop coincides with a tick edge, stop wins: no step that cycle.
- start, steps, dir and half are ignored while in RUN. Changing them mid-move has no effect.
- coil output (combinational from registered state):
  - busy = 1 or hold = 1 → pattern(idx).
  - Otherwise → 0.
- idx and pos are retained across moves and are cleared only by reset.

## Timing
- Reset values:
  - State IDLE, idx = 0, pos = 0, divider = 0, remaining = 0.
  - busy = 0, done = 0.
  - coil = 8 if hold = 1, else 0.
- Reset takes priority over start and stop on the same edge. Reset mid-move aborts without a done pulse.
- start sampled at edge t:
  - busy = 1 after edge t.
  - Step k is applied at edge t + k·CLK_DIV.
- N-step move: the last step, busy → 0 and done = 1 all occur at edge t + N·CLK_DIV. done lasts exactly one cycle.
- Earliest next start: the cycle done is high (FSM is already in IDLE). That start is accepted.
- stop sampled at edge s while busy: busy = 0 and done = 1 after edge s. The divider's partial count is discarded.
- Divider width: ceil(log2(CLK_DIV)) bits. remaining is CNT_W bits; the maximum move is 2^CNT_W − 1 steps.

## Test plan
Bench uses CLK_DIV = 4, CNT_W = 8.
- Reset with hold = 1 → coil = 8, pos = 0, busy = 0. Release hold → coil = 0.
- start, steps = 4, dir = 1, half = 0 at edge 0:
  - coil 4, 2, 1, 8 at edges 4, 8, 12, 16.
  - done = 1 only at edge 16.
  - pos = 8.
- start, steps = 3, dir = 0, half = 1 from idx 0, pos 0:
  - coil 9, 1, 3.
  - pos = 253 (wrap).
  - busy high for exactly 12 cycles.
- start with steps = 0 → done pulse next cycle, busy never high, coil and pos unchanged.
- Move of 10 steps; assert stop on the same edge as the 3rd tick:
  - Only 2 steps taken.
  - done pulses once; busy falls.
  - A start pulsed mid-move, before the stop, is ignored.
- Back-to-back moves: second start issued in the done cycle → accepted. Also assert reset mid-move → idx = 0, pos = 0, no done.
